dcache_wt: RTL and testbench

Write-through, no-write-allocate, direct-mapped data cache that answers the memory stage of the 5-stage pipeline. It takes byte-enabled load and store requests and returns load data the same cycle on a hit. It stalls the pipeline on read misses and on every store. It refills lines from, and forwards stores to, backing data memory over a req/ack handshake.

---
 rtl/dcache_wt.sv | 149 ++++++++++++++
 tb/tb_dcache_wt.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wt.sv
// dcache_wt: write-through, no-write-allocate, direct-mapped data cache for
// the memory stage. Read hits return data combinationally with no stall.
// Read misses refill the whole line (words 0..3) from backing memory. Every
// store is forwarded to memory, and it is merged into the line only if the
// line hits.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   cpu_req/we/addr   pipeline access (held stable while cpu_stall=1)
//   cpu_wdata/be      lane-aligned store data and byte enables
//   cpu_rdata         load word, 0 unless this cycle is a read hit
//   cpu_stall         combinational pipeline freeze
//   mem_req/we/addr   backing-memory request (word-aligned address)
//   mem_wdata/be      store data / byte enables (4'hF on refills)
//   mem_ack/rdata     one-cycle completion, read data valid with ack
module dcache_wt #(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_be,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);
   localparam int IW = $clog2(LINES);
   localparam int TW = 28 - IW;

   typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

   state_t            state;
   logic [1:0]        cnt;
   logic [LINES-1:0]  valid;
   logic [TW-1:0]     tags [LINES];
   logic [31:0]       data [LINES][WORDS];

   logic [IW-1:0]     idx;
   logic [TW-1:0]     tag;
   logic [1:0]        word;
   logic              hit;
   logic              unused;

   assign idx    = cpu_addr[3+IW:4];
   assign tag    = cpu_addr[31:4+IW];
   assign word   = cpu_addr[3:2];
   assign hit    = valid[idx] && (tags[idx] == tag);
   assign unused = ^cpu_addr[1:0];

   // Pipeline-facing outputs are combinational on the live request.
   always_comb begin
      cpu_stall = 1'b0;
      cpu_rdata = '0;
      case (state)
         IDLE: begin
            cpu_stall = cpu_req && (cpu_we || !hit);
            if (cpu_req && !cpu_we && hit) cpu_rdata = data[idx][word];
         end
         REFILL:  cpu_stall = 1'b1;
         WRITE:   cpu_stall = !mem_ack;   // released in the ack cycle
         default: cpu_stall = 1'b0;
      endcase
   end

   // Memory-side outputs decode straight from the state register; cpu_addr
   // is frozen by the stall, so the request address stays stable until ack.
   always_comb begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_be   = '0;
      case (state)
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {cpu_addr[31:4], cnt, 2'b00};
            mem_be   = 4'hF;
         end
         WRITE: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = {cpu_addr[31:2], 2'b00};
            mem_be   = cpu_be;
         end
         default: ;
      endcase
   end

   assign mem_wdata = cpu_wdata;

   // Control state: only this part needs reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         valid <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  if (cpu_we) begin
                     state <= WRITE;
                  end else if (!hit) begin
                     state <= REFILL;
                     cnt   <= '0;
                  end
               end
            end
            REFILL: begin
               if (mem_ack) begin
                  cnt <= cnt + 2'd1;
                  // valid only rises once all four words are in
                  if (cnt == 2'd3) begin
                     valid[idx] <= 1'b1;
                     state      <= IDLE;
                  end
               end
            end
            WRITE: begin
               if (mem_ack) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag and data arrays: no reset, validity alone gates their use. Writes
   // landing on a reset edge are harmless because valid is cleared.
   always_ff @(posedge clk) begin
      if (state == REFILL && mem_ack) begin
         data[idx][cnt] <= mem_rdata;
         if (cnt == 2'd3) tags[idx] <= tag;
      end
      if (state == WRITE && mem_ack && hit) begin
         for (int b = 0; b < 4; b++) begin
            if (cpu_be[b]) data[idx][word][8*b +: 8] <= cpu_wdata[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: directed bench for dcache_wt. A backing-memory responder with
// programmable ack delay logs every transaction; a line-level cache model
// predicts hit/miss, memory traffic, stall length and load data for each
// access; a per-cycle monitor checks output invariants.
module tb_dcache_wt;
   logic        clk, rst_n;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata;
   logic [3:0]  cpu_be;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   dcache_wt #(.LINES(16), .WORDS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } xact_t;

   int tests = 0;
   int fails = 0;

   // environment + model state
   logic [31:0] mem [logic [31:0]];
   xact_t       xlog [$];
   int          delay = 0;
   bit          mvalid [16];
   int          mline  [16];
   logic [31:0] mdata  [16][4];
   logic [31:0] exp_rdata = 0;
   logic        first_mreq;
   bit          chk_en = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   // backing memory: ack after `delay` waiting cycles, one ack per request
   initial begin
      int    wcnt;
      xact_t x;
      mem_ack = 0; mem_rdata = 0; wcnt = 0;
      forever begin
         @(negedge clk);
         if (mem_req && rst_n) begin
            if (wcnt >= delay) begin
               mem_ack = 1;
               wcnt    = 0;
               x.we = mem_we; x.addr = mem_addr; x.be = mem_be;
               x.wdata = mem_we ? mem_wdata : 32'h0;
               if (mem_we) begin
                  mem[mem_addr] = merge(mem_rd(mem_addr), mem_wdata, mem_be);
                  mem_rdata = 0;
               end else begin
                  mem_rdata = mem_rd(mem_addr);
               end
               xlog.push_back(x);
            end else begin
               mem_ack = 0;
               mem_rdata = 0;
               wcnt++;
            end
         end else begin
            mem_ack = 0; mem_rdata = 0; wcnt = 0;
         end
      end
   end

   // per-cycle output invariants
   initial begin
      logic        p_req, p_ack;
      logic [31:0] p_addr;
      p_req = 0; p_ack = 0; p_addr = 0;
      forever begin
         @(negedge clk); #1;
         if (chk_en) begin
            if (!mem_req) begin
               chk("idle_mem_outs", {mem_we, mem_be, mem_addr[26:0]}, 32'h0);
            end else if (mem_we) begin
               chk("wr_wdata", mem_wdata, cpu_wdata);
               chk("wr_be", {28'h0, mem_be}, {28'h0, cpu_be});
            end
            if (p_req && !p_ack && mem_req) chk("mem_addr_stable", mem_addr, p_addr);
            if (cpu_req && !cpu_we && !cpu_stall) chk("hit_rdata", cpu_rdata, exp_rdata);
            else chk("rdata_zero", cpu_rdata, 32'h0);
         end
         p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr;
      end
   end

   // one CPU access; entered and left at posedge+1
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input int d,
                         output int stalls, output logic [31:0] rd);
      int    idx, line, exp_st;
      bit    hit;
      xact_t e;
      xact_t expq [$];
      idx  = int'(addr[7:4]);
      line = int'(addr >> 4);
      hit  = mvalid[idx] && (mline[idx] == line);
      if (we) begin
         e.we = 1; e.addr = {addr[31:2], 2'b00}; e.be = be; e.wdata = wd;
         expq.push_back(e);
         exp_st = 1 + d;
      end else if (!hit) begin
         for (int w = 0; w < 4; w++) begin
            e.we = 0; e.addr = {addr[31:4], 4'h0} + 32'(4*w); e.be = 4'hF; e.wdata = 0;
            expq.push_back(e);
         end
         exp_st = 1 + 4*(d+1);
      end else begin
         exp_st = 0;
      end
      exp_rdata = we ? 32'h0 : (hit ? mdata[idx][addr[3:2]] : mem_rd({addr[31:2], 2'b00}));
      delay = d;
      xlog.delete();
      cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_be = be;
      stalls = 0; rd = 0;
      forever begin
         @(negedge clk); #1;
         if (stalls == 0) first_mreq = mem_req;
         if (!cpu_stall) break;
         stalls++;
         if (stalls > 400) begin
            chk("stall_timeout", 32'(stalls), 32'(exp_st));
            break;
         end
      end
      rd = cpu_rdata;
      @(posedge clk); #1;
      cpu_req = 0; cpu_we = 0; cpu_wdata = 0; cpu_be = 0;
      chk("stall_cycles", 32'(stalls), 32'(exp_st));
      chk("n_xact", 32'(xlog.size()), 32'(expq.size()));
      for (int i = 0; i < expq.size() && i < xlog.size(); i++) begin
         chk("xact_we", {31'h0, xlog[i].we}, {31'h0, expq[i].we});
         chk("xact_addr", xlog[i].addr, expq[i].addr);
         chk("xact_be", {28'h0, xlog[i].be}, {28'h0, expq[i].be});
         if (expq[i].we) chk("xact_wdata", xlog[i].wdata, expq[i].wdata);
      end
      if (!we) chk("load_rdata", rd, exp_rdata);
      if (we && hit) mdata[idx][addr[3:2]] = merge(mdata[idx][addr[3:2]], wd, be);
      if (!we && !hit) begin
         mvalid[idx] = 1;
         mline[idx]  = line;
         for (int w = 0; w < 4; w++) mdata[idx][w] = mem_rd({addr[31:4], 4'h0} + 32'(4*w));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          st;
      logic [31:0] rd;
      rst_n = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0;
      for (int i = 0; i < 16; i++) mvalid[i] = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      chk_en = 1;
      @(negedge clk); #1;
      chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
      chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      @(posedge clk); #1;

      // 1: cold miss, immediate acks
      access(0, 32'h104, 0, 0, 0, st, rd);
      chk("s1_first_mem_req", {31'h0, first_mreq}, 32'h0);
      chk("s1_stall", 32'(st), 32'd5);
      chk("s1_rdata", rd, 32'hA5A5_0104);
      chk("s1_addr0", xlog[0].addr, 32'h100);
      chk("s1_addr1", xlog[1].addr, 32'h104);
      chk("s1_addr2", xlog[2].addr, 32'h108);
      chk("s1_addr3", xlog[3].addr, 32'h10C);

      // 2: hit
      access(0, 32'h10C, 0, 0, 0, st, rd);
      chk("s2_stall", 32'(st), 32'd0);
      chk("s2_rdata", rd, 32'hA5A5_010C);

      // 3: store hit with byte merge, ack delayed 2
      access(1, 32'h108, 32'h0000_EE00, 4'b0010, 2, st, rd);
      chk("s3_stall", 32'(st), 32'd3);
      chk("s3_be", {28'h0, xlog[0].be}, 32'h2);
      access(0, 32'h108, 0, 0, 0, st, rd);
      chk("s3_load_stall", 32'(st), 32'd0);
      chk("s3_load_rdata", rd, 32'hA5A5_EE08);

      // 5: conflict eviction, slow refill (ack delay 2)
      access(0, 32'h204, 0, 0, 2, st, rd);
      chk("s5_stall", 32'(st), 32'd13);
      chk("s5_rdata", rd, 32'hA5A5_0204);
      chk("s5_addr0", xlog[0].addr, 32'h200);
      access(0, 32'h104, 0, 0, 0, st, rd);
      chk("s5_remiss_stall", 32'(st), 32'd5);

      // 4: store miss, no allocate
      access(1, 32'h300, 32'h1234_5678, 4'hF, 0, st, rd);
      chk("s4_stall", 32'(st), 32'd1);
      chk("s4_nx", 32'(xlog.size()), 32'd1);
      access(0, 32'h300, 0, 0, 0, st, rd);
      chk("s4_load_stall", 32'(st), 32'd5);
      chk("s4_load_rdata", rd, 32'h1234_5678);

      // another index is independent of line 0
      access(0, 32'hA14, 0, 0, 1, st, rd);
      chk("idx1_stall", 32'(st), 32'd9);
      access(0, 32'hA18, 0, 0, 0, st, rd);
      chk("idx1_hit_rdata", rd, 32'hA5A5_0A18);
      access(0, 32'h304, 0, 0, 0, st, rd);
      chk("idx0_still_hit", 32'(st), 32'd0);

      // 6: reset after the 2nd refill ack
      delay = 1;
      xlog.delete();
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h104; cpu_be = 0; cpu_wdata = 0;
      for (int k = 0; k < 50 && xlog.size() < 2; k++) begin
         @(negedge clk); #1;
      end
      chk("s6_two_acks", 32'(xlog.size()), 32'd2);
      @(posedge clk); #1;
      rst_n = 0; cpu_req = 0;
      @(posedge clk); #1;
      rst_n = 1;
      for (int i = 0; i < 16; i++) mvalid[i] = 0;
      @(negedge clk); #1;
      chk("s6_mem_req_drop", {31'h0, mem_req}, 32'h0);
      chk("s6_stall_idle", {31'h0, cpu_stall}, 32'h0);
      @(posedge clk); #1;
      access(0, 32'h104, 0, 0, 0, st, rd);
      chk("s6_reload_stall", 32'(st), 32'd5);
      chk("s6_reload_addr0", xlog[0].addr, 32'h100);
      chk("s6_reload_rdata", rd, 32'hA5A5_0104);
      access(0, 32'hA14, 0, 0, 0, st, rd);
      chk("s6_other_invalid", 32'(st), 32'd5);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
